// File: rtl/adc_paddle_reader.sv
// LTC2308 paddle reader: alternately converts two pot channels and scales each code to a screen Y.
// Define ADC_IIR_EN to low-pass filter each paddle output instead of passing the latest sample.
module adc_paddle_reader #(
    parameter int SCK_HALF    = 2,
    parameter int CONV_CYCLES = 80,
    parameter int GAP_CYCLES  = 50,
    parameter int CH_A        = 0,
    parameter int CH_B        = 1,
    parameter int Y_RANGE     = 400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        ADC_CONVST,
    output logic        ADC_SCK,
    output logic        ADC_SDI,
    input  logic        ADC_SDO,
    output logic [15:0] pongbar1_y,
    output logic [15:0] pongbar2_y,
    output logic        sample_valid,
    output logic        sample_ch
);

    localparam logic [15:0] CONV_LAST  = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] SHIFT_LAST = 16'(2 * SCK_HALF - 1);
    localparam logic [15:0] SCK_HIGH   = 16'(SCK_HALF);
    localparam logic [2:0]  CH_A_SEL   = 3'(CH_A);
    localparam logic [2:0]  CH_B_SEL   = 3'(CH_B);
    localparam logic [8:0]  Y_SCALE    = 9'(Y_RANGE);
    localparam logic [8:0]  Y_MAX      = 9'(Y_RANGE - 1);

    typedef enum logic [2:0] {IDLE, CONV, SHIFT, UPDATE, GAP} state_t;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [3:0]  bit_idx, bit_nx;
    logic        convst_nx, sck_nx, sdi_nx, sample_en;
    logic [11:0] data_sr;
    logic        next_sel, prev_sel, prime;
    logic [8:0]  y1, y2, scaled;
    logic [2:0]  cfg_ch;
    logic [5:0]  cfg_word;

    assign cfg_ch     = next_sel ? CH_B_SEL : CH_A_SEL;
    assign cfg_word   = {1'b1, cfg_ch[0], cfg_ch[2], cfg_ch[1], 1'b1, 1'b0};
    assign scaled     = 9'((21'(data_sr) * 21'(Y_SCALE)) >> 12);
    assign pongbar1_y = {7'd0, y1};
    assign pongbar2_y = {7'd0, y2};

`ifdef ADC_IIR_EN
    logic loaded1, loaded2;

    function automatic logic [8:0] iir_step(input logic [8:0] y_old, input logic [8:0] sample);
        logic signed [16:0] diff;
        logic signed [16:0] sum;
        diff = $signed({8'd0, sample}) - $signed({8'd0, y_old});
        sum  = $signed({8'd0, y_old}) + (diff >>> 2);
        if (sum < 0)
            return 9'd0;
        else if (sum > $signed({8'd0, Y_MAX}))
            return Y_MAX;
        else
            return 9'(sum);
    endfunction
`endif

    // Outputs are registered from the next-state decode so the pins never glitch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 16'd1;
        bit_nx   = bit_idx;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                bit_nx = '0;
                if (enable)
                    state_nx = CONV;
            end
            CONV: begin
                if (cnt == CONV_LAST) begin
                    state_nx = SHIFT;
                    cnt_nx   = '0;
                    bit_nx   = '0;
                end
            end
            SHIFT: begin
                if (cnt == SHIFT_LAST) begin
                    cnt_nx = '0;
                    if (bit_idx == 4'd11)
                        state_nx = UPDATE;
                    else
                        bit_nx = bit_idx + 4'd1;
                end
            end
            UPDATE: begin
                state_nx = GAP;
                cnt_nx   = '0;
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                bit_nx   = '0;
            end
        endcase

        convst_nx = (state_nx == CONV);
        sck_nx    = (state_nx == SHIFT) && (cnt_nx >= SCK_HIGH);
        sdi_nx    = 1'b0;
        if ((state_nx == SHIFT) && (bit_nx < 4'd6))
            sdi_nx = cfg_word[3'd5 - bit_nx[2:0]];
        sample_en = sck_nx && !ADC_SCK;
    end

    // The first frame after reset carries an unknown channel, so prime swallows its result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            ADC_CONVST   <= 1'b0;
            ADC_SCK      <= 1'b0;
            ADC_SDI      <= 1'b0;
            data_sr      <= '0;
            next_sel     <= 1'b0;
            prev_sel     <= 1'b0;
            prime        <= 1'b1;
            y1           <= '0;
            y2           <= '0;
            sample_valid <= 1'b0;
            sample_ch    <= 1'b0;
`ifdef ADC_IIR_EN
            loaded1      <= 1'b0;
            loaded2      <= 1'b0;
`endif
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            bit_idx      <= bit_nx;
            ADC_CONVST   <= convst_nx;
            ADC_SCK      <= sck_nx;
            ADC_SDI      <= sdi_nx;
            sample_valid <= 1'b0;
            if (sample_en)
                data_sr <= {data_sr[10:0], ADC_SDO};
            if (state == UPDATE) begin
                next_sel <= ~next_sel;
                prev_sel <= next_sel;
                if (prime) begin
                    prime <= 1'b0;
                end else begin
                    sample_valid <= 1'b1;
                    sample_ch    <= prev_sel;
`ifdef ADC_IIR_EN
                    if (!prev_sel) begin
                        y1      <= loaded1 ? iir_step(y1, scaled) : scaled;
                        loaded1 <= 1'b1;
                    end else begin
                        y2      <= loaded2 ? iir_step(y2, scaled) : scaled;
                        loaded2 <= 1'b1;
                    end
`else
                    if (!prev_sel)
                        y1 <= scaled;
                    else
                        y2 <= scaled;
`endif
                end
            end
        end
    end

endmodule
